// File: rtl/mmio_uart_tx.sv
// Bus-mapped 8N1 serial transmitter: CPU stores to TXDATA fill a small FIFO
// that a start/data/stop shifter drains onto txd. Firmware polls STATUS.
module mmio_uart_tx #(
   parameter logic [15:0] BASE_ADDR    = 16'hFF00,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic        clock,
   input  logic        notReset,
   input  logic [15:0] aBus,
   inout  wire  [15:0] yBus,
   input  logic        memNotCS,
   input  logic        memNotOE,
   input  logic        memNotWE,
   output logic        txd,
   output logic        txBusy
);

   localparam int unsigned DATA_W = 16;
   localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
   localparam int unsigned DIV_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [15:0] STATUS_ADDR = BASE_ADDR + 16'd1;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [DIV_W-1:0]    div_cnt;
   logic [DIV_W-1:0]    div_nxt;
   logic [2:0]          bit_cnt;
   logic [2:0]          bit_nxt;
   logic [7:0]          shift;
   logic [7:0]          shift_nxt;
   logic                txd_nxt;

   logic [DATA_W-1:0]   mem [DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [CNT_W-1:0]    count;
   logic                overflow;
   logic                wr_prev;

   logic                sel_data_c;
   logic                sel_stat_c;
   logic                hit_c;
   logic                wr_c;
   logic                wr_edge_c;
   logic                rd_en_c;
   logic                empty_c;
   logic                full_c;
   logic                push_req_c;
   logic                push_c;
   logic                pop_c;
   logic                ovf_set_c;
   logic                ovf_clr_c;
   logic                bit_end_c;
   logic [DATA_W-1:0]   head_c;
   logic [DATA_W-1:0]   status_c;
   logic [DATA_W-1:0]   rd_data_c;
   logic                unused_head_hi;

   // Address decode and write-strobe edge detection
   assign sel_data_c = (aBus == BASE_ADDR);
   assign sel_stat_c = (aBus == STATUS_ADDR);
   assign hit_c      = !memNotCS && (sel_data_c || sel_stat_c);
   assign wr_c       = hit_c && !memNotWE;
   assign wr_edge_c  = wr_c && !wr_prev;
   assign rd_en_c    = hit_c && !memNotOE && memNotWE;

   assign empty_c    = (count == '0);
   assign full_c     = (count == CNT_W'(DEPTH));
   assign head_c     = mem[rd_ptr];
   assign unused_head_hi = ^head_c[15:8];

   // A push while full still lands if the shifter frees a slot on the same edge
   assign push_req_c = wr_edge_c && sel_data_c;
   assign push_c     = push_req_c && (!full_c || pop_c);
   assign ovf_set_c  = push_req_c && !push_c;
   assign ovf_clr_c  = wr_edge_c && sel_stat_c && yBus[3];

   // Combinational read path, released whenever the CPU is writing
   assign status_c  = {12'b0, overflow, txBusy, empty_c, full_c};
   assign rd_data_c = sel_stat_c ? status_c : '0;
   assign yBus      = rd_en_c ? rd_data_c : {DATA_W{1'bz}};

   assign bit_end_c = (div_cnt == DIV_W'(CLKS_PER_BIT - 1));

   // Shifter next-state, pop request and next serial level
   always_comb begin
      state_nxt = state;
      div_nxt   = div_cnt;
      bit_nxt   = bit_cnt;
      shift_nxt = shift;
      pop_c     = 1'b0;
      txd_nxt   = 1'b1;
      case (state)
         IDLE: begin
            if (!empty_c) begin
               pop_c     = 1'b1;
               shift_nxt = head_c[7:0];
               div_nxt   = '0;
               state_nxt = START;
            end
         end
         START: begin
            if (bit_end_c) begin
               div_nxt   = '0;
               bit_nxt   = '0;
               state_nxt = DATA;
            end else begin
               div_nxt = div_cnt + DIV_W'(1);
            end
         end
         DATA: begin
            if (bit_end_c) begin
               div_nxt   = '0;
               shift_nxt = {1'b0, shift[7:1]};
               bit_nxt   = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  state_nxt = STOP;
               end
            end else begin
               div_nxt = div_cnt + DIV_W'(1);
            end
         end
         STOP: begin
            if (bit_end_c) begin
               div_nxt = '0;
               if (!empty_c) begin
                  pop_c     = 1'b1;
                  shift_nxt = head_c[7:0];
                  state_nxt = START;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               div_nxt = div_cnt + DIV_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase

      // txd trails the state register by one edge, giving the two-cycle start latency
      case (state)
         START:   txd_nxt = 1'b0;
         DATA:    txd_nxt = shift[0];
         default: txd_nxt = 1'b1;
      endcase
   end

   // Shifter registers and registered outputs
   always_ff @(posedge clock) begin
      if (!notReset) begin
         state   <= IDLE;
         div_cnt <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         txd     <= 1'b1;
         txBusy  <= 1'b0;
      end else begin
         state   <= state_nxt;
         div_cnt <= div_nxt;
         bit_cnt <= bit_nxt;
         shift   <= shift_nxt;
         txd     <= txd_nxt;
         txBusy  <= (state_nxt != IDLE);
      end
   end

   // FIFO bookkeeping, write-strobe history and sticky overflow
   always_ff @(posedge clock) begin
      if (!notReset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         wr_prev  <= 1'b0;
      end else begin
         wr_prev <= wr_c;
         if (push_c) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_c) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push_c && !pop_c) begin
            count <= count + CNT_W'(1);
         end else if (!push_c && pop_c) begin
            count <= count - CNT_W'(1);
         end
         if (ovf_set_c) begin
            overflow <= 1'b1;
         end else if (ovf_clr_c) begin
            overflow <= 1'b0;
         end
      end
   end

   // FIFO storage needs no reset; count gates every read of it
   always_ff @(posedge clock) begin
      if (push_c) begin
         mem[wr_ptr] <= yBus;
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: stimulus queues expected bytes, a serial
// monitor decodes txd frames and checks them against the queue.
`timescale 1ns/1ps
module tb_mmio_uart_tx;

   localparam int CPB   = 4;
   localparam int FRAME = 10 * CPB;

   logic        clock = 1'b0;
   logic        notReset;
   logic [15:0] aBus;
   logic        memNotCS;
   logic        memNotOE;
   logic        memNotWE;
   logic        txd;
   logic        txBusy;
   logic        tb_drv;
   logic [15:0] tb_data;
   tri1  [15:0] yBus;

   assign yBus = tb_drv ? tb_data : 16'hzzzz;

   mmio_uart_tx #(
      .BASE_ADDR   (16'hFF00),
      .DEPTH       (4),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clock   (clock),
      .notReset(notReset),
      .aBus    (aBus),
      .yBus    (yBus),
      .memNotCS(memNotCS),
      .memNotOE(memNotOE),
      .memNotWE(memNotWE),
      .txd     (txd),
      .txBusy  (txBusy)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   int         starts[$];
   int         frames_done = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Serial monitor: samples mid-bit on the falling clock edge
   logic       rx_active = 1'b0;
   int         rx_off = 0;
   int         rx_start = 0;
   logic [7:0] rx_byte = 8'h00;
   logic [7:0] rx_exp;

   always @(negedge clock) begin
      if (notReset !== 1'b1) begin
         rx_active = 1'b0;
      end else if (!rx_active) begin
         if (txd == 1'b0) begin
            rx_active = 1'b1;
            rx_off    = 0;
            rx_start  = cyc;
         end
      end else begin
         rx_off++;
         if (rx_off == CPB / 2) begin
            check("start_bit", 32'(txd), 32'h0);
         end else if (rx_off >= CPB + CPB / 2 && rx_off <= 8 * CPB + CPB / 2 && (rx_off % CPB) == CPB / 2) begin
            rx_byte = {txd, rx_byte[7:1]};
         end else if (rx_off == 9 * CPB + CPB / 2) begin
            check("stop_bit", 32'(txd), 32'h1);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL frame_unexpected: got 0x%0h, expected no frame", rx_byte);
            end else begin
               rx_exp = exp_q.pop_front();
               check("frame_data", 32'(rx_byte), 32'(rx_exp));
            end
            starts.push_back(rx_start);
            frames_done++;
            rx_active = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic bus_idle();
      memNotCS = 1'b1;
      memNotOE = 1'b1;
      memNotWE = 1'b1;
      aBus     = 16'h0000;
      tb_drv   = 1'b0;
      tb_data  = 16'h0000;
   endtask

   task automatic bus_write(input logic [15:0] addr, input logic [15:0] data,
                            input int hold, output int wcyc);
      memNotCS = 1'b0;
      memNotOE = 1'b1;
      memNotWE = 1'b0;
      aBus     = addr;
      tb_data  = data;
      tb_drv   = 1'b1;
      tick();
      wcyc = cyc;
      repeat (hold - 1) tick();
      bus_idle();
   endtask

   // Sample yBus mid-cycle with the bench not driving it
   task automatic bus_probe(input logic [15:0] addr, input logic oe_n, input logic we_n,
                            output logic [15:0] d);
      memNotCS = 1'b0;
      memNotOE = oe_n;
      memNotWE = we_n;
      aBus     = addr;
      tb_drv   = 1'b0;
      #2;
      d = yBus;
      bus_idle();
   endtask

   task automatic wait_frames(input int target, input int budget);
      int n = 0;
      while (frames_done < target && n < budget) begin
         tick();
         n++;
      end
      check("wait_frames", 32'(frames_done), 32'(target));
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          w;
      int          w0;
      int          base;
      int          nst;
      logic [15:0] d;
      logic [7:0]  ovf_bytes[6];
      logic [7:0]  b2b_bytes[3];
      ovf_bytes = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
      b2b_bytes = '{8'h01, 8'h02, 8'h03};

      // Reset then idle
      bus_idle();
      notReset = 1'b0;
      tick();
      tick();
      check("rst_txd", 32'(txd), 32'h1);
      check("rst_busy", 32'(txBusy), 32'h0);
      bus_probe(16'hFF01, 1'b0, 1'b1, d);
      check("rst_status", 32'(d), 32'h0002);
      notReset = 1'b1;
      tick();
      bus_probe(16'hFF00, 1'b0, 1'b1, d);
      check("txdata_read", 32'(d), 32'h0000);
      bus_probe(16'hFF02, 1'b0, 1'b1, d);
      check("z_other_addr", 32'(d), 32'hFFFF);
      bus_probe(16'hFF01, 1'b0, 1'b0, d);
      check("z_during_write", 32'(d), 32'hFFFF);

      // Single byte
      base = frames_done;
      exp_q.push_back(8'h55);
      bus_write(16'hFF00, 16'h1255, 1, w);
      bus_probe(16'hFF01, 1'b0, 1'b1, d);
      check("push_status", 32'(d), 32'h0000);
      tick();
      bus_probe(16'hFF01, 1'b0, 1'b1, d);
      check("busy_status", 32'(d), 32'h0006);
      wait_frames(base + 1, 3 * FRAME);
      check("start_latency", 32'(starts[starts.size() - 1] - w), 32'd2);
      repeat (3) tick();
      check("single_idle_busy", 32'(txBusy), 32'h0);
      bus_probe(16'hFF01, 1'b0, 1'b1, d);
      check("single_idle_status", 32'(d), 32'h0002);

      // Held write acts once
      base = frames_done;
      exp_q.push_back(8'hA5);
      bus_write(16'hFF00, 16'h00A5, 10, w);
      tick();
      wait_frames(base + 1, 3 * FRAME);
      repeat (60) tick();
      check("held_once", 32'(frames_done), 32'(base + 1));

      // Overflow with the shifter busy
      base = frames_done;
      for (int i = 0; i < 6; i++) begin
         if (i < 5) exp_q.push_back(ovf_bytes[i]);
         bus_write(16'hFF00, {8'h00, ovf_bytes[i]}, 1, w);
         tick();
      end
      bus_probe(16'hFF01, 1'b0, 1'b1, d);
      check("ovf_status", 32'(d), 32'h000D);
      bus_write(16'hFF01, 16'h0008, 1, w);
      tick();
      bus_probe(16'hFF01, 1'b0, 1'b1, d);
      check("ovf_clear", 32'(d), 32'h0005);
      wait_frames(base + 5, 7 * FRAME);
      repeat (5) tick();
      check("ovf_queue_drained", 32'(exp_q.size()), 32'h0);
      bus_probe(16'hFF01, 1'b0, 1'b1, d);
      check("ovf_idle_status", 32'(d), 32'h0002);

      // Back-to-back frames
      base = frames_done;
      nst  = starts.size();
      w0   = 0;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(b2b_bytes[i]);
         bus_write(16'hFF00, {8'h00, b2b_bytes[i]}, 1, w);
         if (i == 0) w0 = w;
         tick();
      end
      wait_until(w0 + 100);
      bus_probe(16'hFF01, 1'b0, 1'b1, d);
      check("b2b_third_empty", 32'(d), 32'h0006);
      wait_until(w0 + 120);
      check("b2b_busy_end", 32'(txBusy), 32'h1);
      tick();
      check("b2b_busy_fall", 32'(txBusy), 32'h0);
      wait_frames(base + 3, FRAME);
      check("b2b_latency", 32'(starts[nst] - w0), 32'd2);
      check("b2b_gap1", 32'(starts[nst + 1] - starts[nst]), 32'(FRAME));
      check("b2b_gap2", 32'(starts[nst + 2] - starts[nst + 1]), 32'(FRAME));

      // Reset mid-frame abandons the frame and the queued byte
      base = frames_done;
      exp_q.push_back(8'h3C);
      bus_write(16'hFF00, 16'h003C, 1, w0);
      tick();
      exp_q.push_back(8'h5A);
      bus_write(16'hFF00, 16'h005A, 1, w);
      tick();
      wait_until(w0 + 14);
      notReset = 1'b0;
      exp_q.delete();
      tick();
      notReset = 1'b1;
      check("rst_mid_txd", 32'(txd), 32'h1);
      check("rst_mid_busy", 32'(txBusy), 32'h0);
      bus_probe(16'hFF01, 1'b0, 1'b1, d);
      check("rst_mid_empty", 32'(d), 32'h0002);
      repeat (100) tick();
      check("rst_no_residual", 32'(frames_done), 32'(base));

      // Write held across reset release acts once, at the first released edge
      base = frames_done;
      notReset = 1'b0;
      exp_q.push_back(8'h77);
      memNotCS = 1'b0;
      memNotOE = 1'b1;
      memNotWE = 1'b0;
      aBus     = 16'hFF00;
      tb_data  = 16'h0077;
      tb_drv   = 1'b1;
      tick();
      tick();
      notReset = 1'b1;
      tick();
      w = cyc;
      tick();
      tick();
      bus_idle();
      wait_frames(base + 1, 3 * FRAME);
      check("rst_held_latency", 32'(starts[starts.size() - 1] - w), 32'd2);
      repeat (60) tick();
      check("rst_held_once", 32'(frames_done), 32'(base + 1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
